// File: rtl/button_pkg.sv
// Shared types, widths and default timing for the button input bank.
// The defaults target the 40 MHz pixel clock with a 1 kHz sample tick.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_t;

  localparam int DEF_NUM_BTNS            = 4;
  localparam int DEF_CLK_HZ              = 40_000_000;
  localparam int DEF_TICK_HZ             = 1_000;
  localparam int DEF_DEBOUNCE_TICKS      = 20;
  localparam int DEF_REPEAT_DELAY_TICKS  = 500;
  localparam int DEF_REPEAT_PERIOD_TICKS = 100;

  // Bits needed to hold values 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button: qualifies press/release on sample ticks and produces
// level, press/repeat pulses, toggle and long-press flags, all registered.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
  input  logic clk_ss,
  input  logic reset,
  input  logic tick_i,
  input  logic sync_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic long_o
);

  localparam int DB_W   = cntWidth(DEBOUNCE_TICKS);
  localparam int HOLD_W = cntWidth(maxInt(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS));

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] DELAY_FULL  = HOLD_W'(REPEAT_DELAY_TICKS);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_TICKS - 1);

  btn_state_t        state_q, state_d;
  logic [DB_W-1:0]   dbCnt_q, dbCnt_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic              fromRepeat_q, fromRepeat_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              toggle_q, toggle_d;
  logic              long_q, long_d;

  always_ff @(posedge clk_ss or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dbCnt_q      <= '0;
      holdCnt_q    <= '0;
      fromRepeat_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      toggle_q     <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dbCnt_q      <= dbCnt_d;
      holdCnt_q    <= holdCnt_d;
      fromRepeat_q <= fromRepeat_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      toggle_q     <= toggle_d;
      long_q       <= long_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dbCnt_d      = dbCnt_q;
    holdCnt_d    = holdCnt_q;
    fromRepeat_d = fromRepeat_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    toggle_d     = toggle_q;
    long_d       = long_q;

    case (state_q)
      IDLE: begin
        if (sync_i) begin
          state_d = PRESS_WAIT;
          dbCnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync_i) begin
          state_d = IDLE;
          dbCnt_d = '0;
        end else if (tick_i) begin
          if (dbCnt_q == DB_LAST) begin
            state_d   = HELD;
            dbCnt_d   = '0;
            holdCnt_d = '0;
            level_d   = 1'b1;
            press_d   = 1'b1;
            toggle_d  = ~toggle_q;
          end else begin
            dbCnt_d = dbCnt_q + DB_W'(1);
          end
        end
      end

      // Hold count saturates at the delay so the long-press event fires once.
      HELD: begin
        if (!sync_i) begin
          state_d      = RELEASE_WAIT;
          dbCnt_d      = '0;
          fromRepeat_d = 1'b0;
        end else if (tick_i && (holdCnt_q < DELAY_FULL)) begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
          if (holdCnt_q == DELAY_LAST) begin
            long_d = 1'b1;
            if (repeat_en_i) begin
              state_d   = REPEAT;
              holdCnt_d = '0;
              press_d   = 1'b1;
            end
          end
        end
      end

      // Dropping repeat_en parks the counter at the delay: no more pulses.
      REPEAT: begin
        if (!sync_i) begin
          state_d      = RELEASE_WAIT;
          dbCnt_d      = '0;
          fromRepeat_d = 1'b1;
        end else if (!repeat_en_i) begin
          state_d   = HELD;
          holdCnt_d = DELAY_FULL;
        end else if (tick_i) begin
          if (holdCnt_q == PERIOD_LAST) begin
            holdCnt_d = '0;
            press_d   = 1'b1;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
          end
        end
      end

      RELEASE_WAIT: begin
        if (sync_i) begin
          state_d = fromRepeat_q ? REPEAT : HELD;
        end else if (tick_i) begin
          if (dbCnt_q == DB_LAST) begin
            state_d   = IDLE;
            dbCnt_d   = '0;
            holdCnt_d = '0;
            level_d   = 1'b0;
            long_d    = 1'b0;
            release_d = 1'b1;
          end else begin
            dbCnt_d = dbCnt_q + DB_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_bank.sv
// N-channel button front end on clk_ss: two-flop synchronisers, a shared
// sample-tick prescaler and one debounce/repeat channel per button.
module button_bank
  import button_pkg::*;
#(
  parameter int NUM_BTNS            = DEF_NUM_BTNS,
  parameter int CLK_HZ              = DEF_CLK_HZ,
  parameter int TICK_HZ             = DEF_TICK_HZ,
  parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
  parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
  input  logic                clk_ss,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in_i,
  input  logic [NUM_BTNS-1:0] repeat_en_i,
  output logic [NUM_BTNS-1:0] btn_level_o,
  output logic [NUM_BTNS-1:0] btn_press_o,
  output logic [NUM_BTNS-1:0] btn_release_o,
  output logic [NUM_BTNS-1:0] btn_toggle_o,
  output logic [NUM_BTNS-1:0] btn_long_o,
  output logic                tick_o
);

  localparam int TICK_DIV = ((CLK_HZ / TICK_HZ) < 2) ? 2 : (CLK_HZ / TICK_HZ);
  localparam int DIV_W    = cntWidth(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]    divCnt_q, divCnt_d;
  logic [NUM_BTNS-1:0] syncA_q, syncB_q;
  logic                tick;

  // Tick is a decode of the prescaler register, high in its terminal count.
  assign tick     = (divCnt_q == DIV_LAST);
  assign divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
  assign tick_o   = tick;

  always_ff @(posedge clk_ss or posedge reset) begin
    if (reset) begin
      divCnt_q <= '0;
      syncA_q  <= '0;
      syncB_q  <= '0;
    end else begin
      divCnt_q <= divCnt_d;
      syncA_q  <= btn_in_i;
      syncB_q  <= syncA_q;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : gChan
    button_channel #(
      .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS(REPEAT_PERIOD_TICKS)
    ) uChan (
      .clk_ss     (clk_ss),
      .reset      (reset),
      .tick_i     (tick),
      .sync_i     (syncB_q[g]),
      .repeat_en_i(repeat_en_i[g]),
      .level_o    (btn_level_o[g]),
      .press_o    (btn_press_o[g]),
      .release_o  (btn_release_o[g]),
      .toggle_o   (btn_toggle_o[g]),
      .long_o     (btn_long_o[g])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected press/release pulses are queued
// with the tick number they must appear after, and matched as they occur.
module tb_button_bank;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int PER  = 5;
  localparam int TDIV = 10;

  logic          clk_ss = 1'b0;
  logic          reset;
  logic [NB-1:0] btnIn, repeatEn;
  logic [NB-1:0] level, press, rel, toggle, longP;
  logic          tick;

  always #5 clk_ss = ~clk_ss;

  button_bank #(
    .NUM_BTNS(NB), .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY_TICKS(DLY), .REPEAT_PERIOD_TICKS(PER)
  ) dut (
    .clk_ss(clk_ss), .reset(reset), .btn_in_i(btnIn), .repeat_en_i(repeatEn),
    .btn_level_o(level), .btn_press_o(press), .btn_release_o(rel),
    .btn_toggle_o(toggle), .btn_long_o(longP), .tick_o(tick)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  int          tickNum    = 0;
  int          base;
  int          cyc;
  logic [31:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event code: channel in [31:28], kind in [27:24] (1 press, 2 release), tick number below.
  function automatic logic [31:0] evCode(input int ch, input int kind, input int tk);
    return (32'(ch) << 28) | (32'(kind) << 24) | 32'(tk);
  endfunction

  task automatic observe(input logic [31:0] obs);
    if (expQ.size() == 0) checkOutput("unexpected_pulse", obs, 32'h0);
    else                  checkOutput("pulse", obs, expQ.pop_front());
  endtask

  // A pulse caused by tick k is visible one cycle later, when tickNum already equals k.
  always @(negedge clk_ss) begin
    for (int c = 0; c < NB; c++) begin
      if (press[c] === 1'b1) observe(evCode(c, 1, tickNum));
      if (rel[c] === 1'b1)   observe(evCode(c, 2, tickNum));
    end
    if (tick === 1'b1) tickNum++;
  end

  task automatic applyStimulus(input int ch, input logic val);
    btnIn[ch] = val;
  endtask

  task automatic waitTicks(input int n);
    int target;
    int budget;
    target = tickNum + n;
    budget = n * TDIV * 2 + 20;
    while ((tickNum < target) && (budget > 0)) begin
      @(negedge clk_ss);
      #1;
      budget--;
    end
    if (tickNum < target) checkOutput("tick_timeout", 32'(tickNum), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at tick %0d", tickNum);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    btnIn    = '0;
    repeatEn = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk_ss);
    checkOutput("reset_outputs", 32'({level, press, rel, toggle, longP, tick}), 32'h0);
    #1 reset = 1'b0;

    // Tick period
    waitTicks(1);
    cyc = 0;
    do begin
      @(negedge clk_ss);
      cyc++;
    end while ((tick !== 1'b1) && (cyc < 50));
    #1;
    checkOutput("tick_period", 32'(cyc), 32'(TDIV));

    // Clean press and release on channel 0
    base = tickNum;
    applyStimulus(0, 1'b1);
    expQ.push_back(evCode(0, 1, base + DEB));
    waitTicks(DEB + 2);
    checkOutput("clean_level", 32'(level), 32'h1);
    checkOutput("clean_toggle", 32'(toggle), 32'h1);
    checkOutput("clean_long", 32'(longP), 32'h0);
    base = tickNum;
    applyStimulus(0, 1'b0);
    expQ.push_back(evCode(0, 2, base + DEB));
    waitTicks(DEB + 2);
    checkOutput("clean_rel_level", 32'(level), 32'h0);
    checkOutput("clean_pending", 32'(expQ.size()), 32'h0);

    // Bouncing input on channel 1 never qualifies
    for (int i = 0; i < 200; i++) begin
      if (i % 7 == 0) applyStimulus(1, ~btnIn[1]);
      @(negedge clk_ss);
      #1;
    end
    applyStimulus(1, 1'b0);
    waitTicks(DEB + 2);
    checkOutput("bounce_level", 32'(level), 32'h0);
    checkOutput("bounce_toggle", 32'(toggle), 32'h1);

    // Auto-repeat on channel 2: press, long at +20 ticks, then every 5 ticks
    repeatEn[2] = 1'b1;
    base = tickNum;
    applyStimulus(2, 1'b1);
    expQ.push_back(evCode(2, 1, base + DEB));
    for (int k = 0; k < 8; k++) expQ.push_back(evCode(2, 1, base + DEB + DLY + k * PER));
    waitTicks(DEB + DLY - 1);
    checkOutput("rep_long_before", 32'(longP), 32'h0);
    waitTicks(2);
    checkOutput("rep_long_after", 32'(longP), 32'h4);
    waitTicks(35);
    applyStimulus(2, 1'b0);
    expQ.push_back(evCode(2, 2, base + 60 + DEB));
    waitTicks(DEB + 2);
    checkOutput("rep_level", 32'(level), 32'h0);
    checkOutput("rep_long_clear", 32'(longP), 32'h0);
    checkOutput("rep_toggle", 32'(toggle), 32'h5);
    checkOutput("rep_pending", 32'(expQ.size()), 32'h0);

    // Long press without repeat on channel 3
    base = tickNum;
    applyStimulus(3, 1'b1);
    expQ.push_back(evCode(3, 1, base + DEB));
    waitTicks(DEB + DLY - 1);
    checkOutput("long_before", 32'(longP), 32'h0);
    waitTicks(2);
    checkOutput("long_after", 32'(longP), 32'h8);
    waitTicks(5);
    applyStimulus(3, 1'b0);
    expQ.push_back(evCode(3, 2, base + 30 + DEB));
    waitTicks(DEB - 1);
    checkOutput("long_held_in_release", 32'({level, longP}), 32'h88);
    waitTicks(2);
    checkOutput("long_released", 32'({level, longP}), 32'h00);
    checkOutput("long_toggle", 32'(toggle), 32'hD);

    // Release glitch during repeat: the hold count pauses for the two dropped
    // ticks, then the 5-tick cadence resumes with no release.
    base = tickNum;
    applyStimulus(2, 1'b1);
    expQ.push_back(evCode(2, 1, base + DEB));
    expQ.push_back(evCode(2, 1, base + 24));
    expQ.push_back(evCode(2, 1, base + 29));
    expQ.push_back(evCode(2, 1, base + 34));
    expQ.push_back(evCode(2, 1, base + 41));
    expQ.push_back(evCode(2, 1, base + 46));
    waitTicks(35);
    applyStimulus(2, 1'b0);
    waitTicks(2);
    checkOutput("glitch_level", 32'(level), 32'h4);
    applyStimulus(2, 1'b1);
    waitTicks(10);
    applyStimulus(2, 1'b0);
    expQ.push_back(evCode(2, 2, base + 47 + DEB));
    waitTicks(DEB + 2);
    checkOutput("glitch_rel_level", 32'(level), 32'h0);
    checkOutput("glitch_toggle", 32'(toggle), 32'h9);
    checkOutput("glitch_pending", 32'(expQ.size()), 32'h0);

    // Reset while repeating with the button held
    base = tickNum;
    applyStimulus(2, 1'b1);
    expQ.push_back(evCode(2, 1, base + DEB));
    expQ.push_back(evCode(2, 1, base + 24));
    expQ.push_back(evCode(2, 1, base + 29));
    waitTicks(31);
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", 32'({level, press, rel, toggle, longP, tick}), 32'h0);
    checkOutput("midreset_pending", 32'(expQ.size()), 32'h0);
    repeat (3) @(negedge clk_ss);
    #1 reset = 1'b0;
    base = tickNum;
    expQ.push_back(evCode(2, 1, base + DEB));
    waitTicks(DEB + 2);
    checkOutput("postreset_level", 32'(level), 32'h4);
    checkOutput("postreset_toggle", 32'(toggle), 32'h4);
    checkOutput("postreset_long", 32'(longP), 32'h0);
    base = tickNum;
    applyStimulus(2, 1'b0);
    expQ.push_back(evCode(2, 2, base + DEB));
    waitTicks(DEB + 2);
    checkOutput("postreset_rel_level", 32'(level), 32'h0);

    checkOutput("final_pending", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised N-channel successor to the single-button input processor. Provides synchronisation, tick-based debouncing, edge pulses, toggle, long-press and hold-to-auto-repeat per channel.
- Runs directly on the 40 MHz pixel-domain clock clk_ss, with an internal prescaled sample tick, so that game control logic (start, difficulty up/down) consumes clean single-cycle events in its own domain.

Parameters:
- NUM_BTNS, 4: number of independent button channels (1..16).
- CLK_HZ, 40000000: clk_ss frequency.
- TICK_HZ, 1000: debounce/hold sample rate. TICK_DIV = CLK_HZ/TICK_HZ, minimum 2.
- DEBOUNCE_TICKS, 20: consecutive ticks a changed input must persist (minimum 1).
- REPEAT_DELAY_TICKS, 500: hold ticks before long-press and the first auto-repeat.
- REPEAT_PERIOD_TICKS, 100: ticks between auto-repeat pulses (minimum 1).

Ports:
- clk_ss, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high. Clock is clk_ss.
- btn_in, in, NUM_BTNS: raw asynchronous noisy buttons, active-high.
- repeat_en, in, NUM_BTNS: per-channel auto-repeat enable, synchronous to clk_ss.
- btn_level, out, NUM_BTNS: debounced level.
- btn_press, out, NUM_BTNS: 1-cycle pulse on debounced rise and on each auto-repeat.
- btn_release, out, NUM_BTNS: 1-cycle pulse on debounced fall.
- btn_toggle, out, NUM_BTNS: flips on each debounced rise only; repeats do not flip it.
- btn_long, out, NUM_BTNS: high from hold count = REPEAT_DELAY_TICKS until release.
- tick, out, 1: sample-tick pulse, exported for the countdown/score timers.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops, debounce and hold counters, and prescaler all 0.
  - Every channel in state IDLE.
- Synchroniser: 2 flops per channel, no reset dependency on data path value (reset to 0 anyway).
- Prescaler: counter runs 0..TICK_DIV-1. tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1, then the counter wraps to 0. First tick comes TICK_DIV cycles after reset release.
- Per-channel FSM, states IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT:
  - IDLE: sync=1 -> PRESS_WAIT, db_cnt=0.
  - PRESS_WAIT:
    - sync=0 on any cycle -> IDLE, db_cnt=0 (glitch rejected, no outputs).
    - On a tick with sync=1, db_cnt++.
    - On the tick where db_cnt reaches DEBOUNCE_TICKS -> HELD. Set btn_level=1, pulse btn_press, flip btn_toggle, hold_cnt=0.
  - HELD:
    - On each tick, hold_cnt++ (saturating at REPEAT_DELAY_TICKS).
    - On reaching REPEAT_DELAY_TICKS, btn_long=1. If repeat_en=1 on that cycle: pulse btn_press, hold_cnt=0, -> REPEAT.
    - sync=0 -> RELEASE_WAIT, db_cnt=0.
  - REPEAT:
    - On each tick, hold_cnt++.
    - On reaching REPEAT_PERIOD_TICKS: pulse btn_press, hold_cnt=0.
    - repeat_en dropping -> HELD with btn_long held 1 and no further pulses.
    - sync=0 -> RELEASE_WAIT.
  - RELEASE_WAIT:
    - sync=1 on any cycle -> return to the originating state (HELD or REPEAT, remembered by 1 flop) with hold_cnt preserved.
    - On a tick with sync=0, db_cnt++. On reaching DEBOUNCE_TICKS: btn_level=0, btn_long=0, pulse btn_release -> IDLE.
- Outputs are registered. Pulses are high exactly 1 clk_ss cycle: the cycle after the qualifying tick.
- Latency from a clean input edge: 2 sync cycles + DEBOUNCE_TICKS ticks + 1 cycle.
- Press and release pulses can never coincide on one channel. Channels are fully independent; simultaneous events on several channels all appear in the same cycle.
- Counters are sized $clog2(max+1); no wrap is possible due to saturation/clear.
- Asserting reset mid-operation returns everything to reset values immediately. No pulse is emitted on reset exit even if buttons are held: a held button re-qualifies through PRESS_WAIT and then produces a press.

Decomposition:
- Package button_pkg:
  - btn_state_t enum (5 states, 3 bits).
  - Function for counter width.
  - Default timing constants for the 40 MHz build.
- Sub-module button_channel: one FSM plus counters, with tick, sync bit and repeat_en as inputs. It is instantiated NUM_BTNS times by generate.
- Prescaler and synchroniser live in button_bank.

Test Plan:
All scenarios use NUM_BTNS=4, CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DEBOUNCE_TICKS=4, REPEAT_DELAY_TICKS=20, REPEAT_PERIOD_TICKS=5.
- Clean press: btn_in[0] held high -> btn_level[0]=1 and a single btn_press[0] pulse about 4 ticks (40-50 cycles) later. btn_toggle[0] goes 0->1; other channels stay 0.
- Bounce rejection: btn_in[1] toggling every 7 cycles for 200 cycles, then low -> no press, release or level change ever.
- Auto-repeat: repeat_en[2]=1, hold 60 ticks -> press at debounce, btn_long at +20 ticks, repeats at +20, +25, +30 ... ticks (9 pulses total). btn_toggle flips once. Release gives one btn_release.
- Long-press without repeat: repeat_en[3]=0, hold 30 ticks -> exactly 1 press, btn_long=1 from tick 20 until the debounced release.
- Release glitch: while held, drop input for 2 ticks then restore -> no release, level stays 1, repeat cadence unaffected.
- Reset mid-hold: assert reset during REPEAT with button held -> all outputs 0 within the same cycle. After release of reset, one press after 4 ticks, no release pulse.
